mf_vec_loader: RTL

// - Serial-to-parallel front end for the mf 20-lane MAC: one (data, weight) sample per cycle in, one

---
 rtl/mf_vec_loader_if.sv | 29 ++
 rtl/mf_vec_loader.sv | 81 ++++++++
 2 files changed

// File: rtl/mf_vec_loader_if.sv
// Sample-in / vector-out bundle between a sample source and the mf vector loader.
// The loader side uses the slave modport; whoever feeds samples uses master.
interface mf_vec_loader_if #(
   parameter int NLANE = 20,
   parameter int DW    = 32,
   parameter int CW    = 16
);
   logic                  in_valid;
   logic                  in_last;
   logic [DW-1:0]         in_d;
   logic [DW-1:0]         in_w;
   logic                  w_hold;
   logic                  clear;
   logic                  out_push;
   logic [NLANE*DW-1:0]   out_d;
   logic [NLANE*DW-1:0]   out_w;
   logic [4:0]            lane_idx;
   logic [CW-1:0]         vec_cnt;

   modport master (
      output in_valid, in_last, in_d, in_w, w_hold, clear,
      input  out_push, out_d, out_w, lane_idx, vec_cnt
   );

   modport slave (
      input  in_valid, in_last, in_d, in_w, w_hold, clear,
      output out_push, out_d, out_w, lane_idx, vec_cnt
   );
endinterface

// File: rtl/mf_vec_loader.sv
// Serial-to-parallel loader: collects one (data, weight) sample per cycle into an
// NLANE-wide vector and presents it with a one-cycle push to the mf MAC.
module mf_vec_loader #(
   parameter int NLANE = 20,
   parameter int DW    = 32,
   parameter int CW    = 16
) (
   input  logic            clk,
   input  logic            reset,
   mf_vec_loader_if.slave  bus
);
   typedef logic [NLANE-1:0][DW-1:0] vec_t;

   vec_t       fill_d, fill_w;
   vec_t       out_d, out_w;
   vec_t       wr_d, wr_w;
   vec_t       cls_d, cls_w;
   logic [4:0] lane_idx;
   logic [CW-1:0] vec_cnt;
   logic       out_push;
   logic       accept;
   logic       closing;

   assign accept  = bus.in_valid && !bus.clear;
   assign closing = accept && (bus.in_last || lane_idx == 5'(NLANE-1));

   // wr_*: fill contents with this cycle's sample merged in.
   // cls_*: the vector emitted if this sample closes it (lanes above padded).
   always_comb begin
      wr_d  = fill_d;
      wr_w  = fill_w;
      cls_d = '0;
      cls_w = '0;
      for (int k = 0; k < NLANE; k++) begin
         if (accept && lane_idx == 5'(k)) begin
            wr_d[k] = bus.in_d;
            if (!bus.w_hold) wr_w[k] = bus.in_w;
         end
         cls_d[k] = (5'(k) > lane_idx) ? '0 : wr_d[k];
         cls_w[k] = (5'(k) > lane_idx && !bus.w_hold) ? '0 : wr_w[k];
      end
   end

   // Weight fill regs follow the emitted vector on close so w_hold reuses
   // exactly what mf last saw.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_d   <= '0;
         fill_w   <= '0;
         out_d    <= '0;
         out_w    <= '0;
         lane_idx <= '0;
         vec_cnt  <= '0;
         out_push <= 1'b0;
      end else begin
         out_push <= 1'b0;
         if (bus.clear) begin
            lane_idx <= '0;
            fill_d   <= '0;
         end else if (closing) begin
            out_d    <= cls_d;
            out_w    <= cls_w;
            fill_w   <= cls_w;
            fill_d   <= '0;
            lane_idx <= '0;
            vec_cnt  <= vec_cnt + 1'b1;
            out_push <= 1'b1;
         end else if (accept) begin
            fill_d   <= wr_d;
            fill_w   <= wr_w;
            lane_idx <= lane_idx + 1'b1;
         end
      end
   end

   assign bus.out_d    = out_d;
   assign bus.out_w    = out_w;
   assign bus.lane_idx = lane_idx;
   assign bus.vec_cnt  = vec_cnt;
   assign bus.out_push = out_push;
endmodule
